// File: rtl/sb_tx_scheduler_if.sv
// Sideband TX scheduler bus: requester handshake, pattern handoff,
// serializer handshake and response-tracking signals.
interface sb_tx_scheduler_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    i_req_valid;
    logic [64*NUM_REQ-1:0] i_req_packet;
    logic [NUM_REQ-1:0]    i_req_needs_rsp;
    logic [NUM_REQ-1:0]    o_req_ack;
    logic                  i_pattern_req;
    logic                  o_pattern_gnt;
    logic                  i_ser_done;
    logic                  o_packet_valid;
    logic [63:0]           o_packet;
    logic                  i_rsp_received;
    logic                  o_timeout_ctr_start;
    logic [2:0]            o_outstanding_cnt;
    logic                  o_rsp_underflow;
    logic                  o_busy;

    // Scheduler side
    modport master (
        input  i_req_valid, i_req_packet, i_req_needs_rsp, i_pattern_req,
               i_ser_done, i_rsp_received,
        output o_req_ack, o_pattern_gnt, o_packet_valid, o_packet,
               o_timeout_ctr_start, o_outstanding_cnt, o_rsp_underflow, o_busy
    );

    // Requester / serializer side
    modport slave (
        output i_req_valid, i_req_packet, i_req_needs_rsp, i_pattern_req,
               i_ser_done, i_rsp_received,
        input  o_req_ack, o_pattern_gnt, o_packet_valid, o_packet,
               o_timeout_ctr_start, o_outstanding_cnt, o_rsp_underflow, o_busy
    );
endinterface

// File: rtl/sb_tx_scheduler.sv
// Sideband TX scheduler: round-robin arbitration among packet requesters,
// absolute priority for the start-pattern generator, one packet on the line
// until the serializer finishes, then a fixed idle gap. Tracks packets that
// expect a response and kicks the response timeout counter.
module sb_tx_scheduler #(
    parameter int NUM_REQ         = 3,
    parameter int GAP_CYCLES      = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    sb_tx_scheduler_if.master    bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Gap counter counts down to zero, so it is loaded one short.
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam logic [2:0] MAX_OUT  = 3'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, PATTERN, SEND, GAP} state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [3:0]         gap_q;
    logic               rsp_flag_q;
    logic [63:0]        packet_q;
    logic               packet_valid_q;
    logic               pattern_gnt_q;
    logic [NUM_REQ-1:0] req_ack_q;
    logic [2:0]         outstanding_q;
    logic               tstart_q;
    logic               underflow_q;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   ptr_d;
    logic [63:0]        win_packet;
    logic               win_needs_rsp;
    logic               rsp_inc;
    logic               rsp_dec;

    // Pick the first eligible requester scanning upward from the RR pointer;
    // response-expecting packets are held back once the in-flight limit is hit.
    always_comb begin
        win_found     = 1'b0;
        win_idx       = '0;
        win_packet    = 64'h0;
        win_needs_rsp = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && bus.i_req_valid[idx] &&
                (!bus.i_req_needs_rsp[idx] || outstanding_q < MAX_OUT)) begin
                win_found     = 1'b1;
                win_idx       = PTR_W'(idx);
                win_packet    = bus.i_req_packet[idx*64 +: 64];
                win_needs_rsp = bus.i_req_needs_rsp[idx];
            end
        end
        ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    assign rsp_inc = (state_q == SEND) && bus.i_ser_done && rsp_flag_q;
    assign rsp_dec = bus.i_rsp_received;

    // Line-ownership FSM with registered grant, ack and packet outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            gap_q          <= 4'd0;
            rsp_flag_q     <= 1'b0;
            packet_q       <= 64'h0;
            packet_valid_q <= 1'b0;
            pattern_gnt_q  <= 1'b0;
            req_ack_q      <= '0;
        end else begin
            req_ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.i_pattern_req) begin
                        state_q       <= PATTERN;
                        pattern_gnt_q <= 1'b1;
                    end else if (win_found) begin
                        packet_q       <= win_packet;
                        rsp_flag_q     <= win_needs_rsp;
                        req_ack_q      <= NUM_REQ'(1) << win_idx;
                        ptr_q          <= ptr_d;
                        packet_valid_q <= 1'b1;
                        state_q        <= SEND;
                    end
                end
                PATTERN: begin
                    if (!bus.i_pattern_req) begin
                        pattern_gnt_q <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            state_q <= GAP;
                            gap_q   <= GAP_LOAD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                SEND: begin
                    if (bus.i_ser_done) begin
                        packet_valid_q <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            state_q <= GAP;
                            gap_q   <= GAP_LOAD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == 4'd0) state_q <= IDLE;
                    else               gap_q   <= gap_q - 4'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outstanding-response counter; a completion and a response in the same
    // cycle cancel out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            outstanding_q <= 3'd0;
            tstart_q      <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            tstart_q    <= rsp_inc;
            underflow_q <= 1'b0;
            if (rsp_inc && !rsp_dec) begin
                if (outstanding_q < MAX_OUT) outstanding_q <= outstanding_q + 3'd1;
            end else if (rsp_dec && !rsp_inc) begin
                if (outstanding_q == 3'd0) underflow_q   <= 1'b1;
                else                       outstanding_q <= outstanding_q - 3'd1;
            end
        end
    end

    assign bus.o_req_ack           = req_ack_q;
    assign bus.o_pattern_gnt       = pattern_gnt_q;
    assign bus.o_packet_valid      = packet_valid_q;
    assign bus.o_packet            = packet_q;
    assign bus.o_timeout_ctr_start = tstart_q;
    assign bus.o_outstanding_cnt   = outstanding_q;
    assign bus.o_rsp_underflow     = underflow_q;
    assign bus.o_busy              = (state_q != IDLE);
endmodule
